// File: rtl/ldpc_qkd_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_qkd_pkg
// Shared sizing and LLR types for the LDPC reconciliation input path.
//   N       frame length in bits (variable-node count)
//   LOG2N   width of a bit index / LLR read address
//   INT     LLR integer bits
//   FRAC    LLR fraction bits
//   W       LLR width, two's complement (INT + FRAC)
//   FCNT_W  width of the completed-frame counter
// ---------------------------------------------------------------------------
package ldpc_qkd_pkg;

    localparam int N      = 12;
    localparam int LOG2N  = 4;
    localparam int INT    = 8;
    localparam int FRAC   = 8;
    localparam int W      = INT + FRAC;
    localparam int FCNT_W = 16;

    typedef logic signed [W-1:0] llr_t;    // signed belief
    typedef logic        [W-2:0] mag_t;    // unsigned channel magnitude
    typedef logic        [N-1:0] frame_t;  // one hard-decision frame

    localparam llr_t LLR_ZERO = '0;

    // Hard bit 0 maps to +mag, hard bit 1 to -mag, so the decoder's sign
    // bit equals the hard decision.
    function automatic llr_t llr_from_bit(input logic hard_bit, input mag_t mag);
        llr_t pos;
        pos = $signed({1'b0, mag});
        return hard_bit ? -pos : pos;
    endfunction

endpackage

// File: rtl/llr_frame_bank.sv
// ---------------------------------------------------------------------------
// llr_frame_bank
// One half of the ping-pong frame buffer: N data bits written one index at a
// time, the magnitude latched when the frame completes, and an EMPTY/FULL flag.
// Optional erasure mask when LLR_FRAME_LOADER_ERASURE_EN is defined.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   wr_en             write wr_bit (and wr_erase) to index wr_idx
//   complete          last bit of frame: set full, latch complete_mag
//   release_bank      decoder has finished with this bank: clear full
//   data, mag, full   stored frame bits, latched magnitude, full flag
//   erase_mask        per-bit erasure flags (erasure build only)
// ---------------------------------------------------------------------------
module llr_frame_bank
    import ldpc_qkd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [LOG2N-1:0] wr_idx,
    input  logic             wr_bit,
`ifdef LLR_FRAME_LOADER_ERASURE_EN
    input  logic             wr_erase,
    output frame_t           erase_mask,
`endif
    input  logic             complete,
    input  mag_t             complete_mag,
    input  logic             release_bank,
    output frame_t           data,
    output mag_t             mag,
    output logic             full
);

    frame_t data_q, data_d;
    mag_t   mag_q,  mag_d;
    logic   full_q, full_d;
`ifdef LLR_FRAME_LOADER_ERASURE_EN
    frame_t mask_q, mask_d;
`endif

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        data_d = data_q;
        mag_d  = mag_q;
        full_d = full_q;
`ifdef LLR_FRAME_LOADER_ERASURE_EN
        mask_d = mask_q;
`endif
        if (wr_en) begin
            for (int i = 0; i < N; i++) begin
                if (wr_idx == LOG2N'(i)) begin
                    data_d[i] = wr_bit;
`ifdef LLR_FRAME_LOADER_ERASURE_EN
                    mask_d[i] = wr_erase;
`endif
                end
            end
        end
        // complete and release_bank are mutually exclusive: a bank is only
        // completed while empty and only released while full.
        if (complete) begin
            full_d = 1'b1;
            mag_d  = complete_mag;
        end else if (release_bank) begin
            full_d = 1'b0;
        end
    end

    // NOTE: the frame storage is a handful of flops, so it is reset along with
    // the flag; stale bits are also masked downstream by the full flag.
    // NOTE: state updates use non-blocking assignments so every flop samples
    // its _d value from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            mag_q  <= '0;
            full_q <= 1'b0;
`ifdef LLR_FRAME_LOADER_ERASURE_EN
            mask_q <= '0;
`endif
        end else begin
            data_q <= data_d;
            mag_q  <= mag_d;
            full_q <= full_d;
`ifdef LLR_FRAME_LOADER_ERASURE_EN
            mask_q <= mask_d;
`endif
        end
    end

    assign data = data_q;
    assign mag  = mag_q;
    assign full = full_q;
`ifdef LLR_FRAME_LOADER_ERASURE_EN
    assign erase_mask = mask_q;
`endif

endmodule

// File: rtl/llr_frame_loader.sv
// ---------------------------------------------------------------------------
// llr_frame_loader
// Input stage ahead of the LDPC decoder. Serial key bits are packed into
// N-bit frames in a two-bank ping-pong buffer; the bank being read is shown
// as a hard-decision word and as per-bit signed LLRs on a registered port.
// Optional feature macro: LLR_FRAME_LOADER_ERASURE_EN (adds din_erase and a
// per-bank erasure mask; erased bits read as LLR 0 and hard bit 0).
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   llr_mag                unsigned channel magnitude, latched per frame
//   din, din_valid         serial key bit and its qualifier
//   din_ready              write bank is empty and can take a bit
//   din_erase              bit is erased (erasure build only)
//   frame_valid            read bank holds a complete frame
//   frame_data             hard bits of the read bank, bit i = i-th bit in
//   frame_done             decoder releases the read bank (1-cycle pulse)
//   rd_addr, llr_out       LLR read index and its result one cycle later
//   frame_count            frames completed since reset (wrapping)
// ---------------------------------------------------------------------------
module llr_frame_loader
    import ldpc_qkd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [W-2:0]      llr_mag,
    input  logic              din,
    input  logic              din_valid,
    output logic              din_ready,
`ifdef LLR_FRAME_LOADER_ERASURE_EN
    input  logic              din_erase,
`endif
    output logic              frame_valid,
    output logic [N-1:0]      frame_data,
    input  logic              frame_done,
    input  logic [LOG2N-1:0]  rd_addr,
    output logic signed [W-1:0] llr_out,
    output logic [FCNT_W-1:0] frame_count
);

    logic              wr_bank_q,     wr_bank_d;
    logic              rd_bank_q,     rd_bank_d;
    logic [LOG2N-1:0]  bit_cnt_q,     bit_cnt_d;
    logic [FCNT_W-1:0] frame_count_q, frame_count_d;
    llr_t              llr_out_q,     llr_out_d;

    logic   accept;
    logic   last_beat;
    logic   frame_release;
    frame_t rd_visible;
    logic   rd_hit;
    logic   rd_bit;

    frame_t bank_data [2];
    mag_t   bank_mag  [2];
    logic   bank_full [2];
`ifdef LLR_FRAME_LOADER_ERASURE_EN
    frame_t bank_mask [2];
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        llr_frame_bank u_bank (
            .clk          (clk),
            .rst          (rst),
            .wr_en        (accept && (wr_bank_q == 1'(b))),
            .wr_idx       (bit_cnt_q),
            .wr_bit       (din),
`ifdef LLR_FRAME_LOADER_ERASURE_EN
            .wr_erase     (din_erase),
            .erase_mask   (bank_mask[b]),
`endif
            .complete     (last_beat && (wr_bank_q == 1'(b))),
            .complete_mag (llr_mag),
            .release_bank (frame_release && (rd_bank_q == 1'(b))),
            .data         (bank_data[b]),
            .mag          (bank_mag[b]),
            .full         (bank_full[b])
        );
    end

    always_comb begin
        din_ready     = !bank_full[wr_bank_q];
        accept        = din_valid && din_ready;
        last_beat     = accept && (bit_cnt_q == LOG2N'(N - 1));
        frame_valid   = bank_full[rd_bank_q];
        // A release with nothing to release is simply ignored.
        frame_release = frame_done && frame_valid;

        bit_cnt_d     = bit_cnt_q;
        if (accept) begin
            bit_cnt_d = last_beat ? '0 : bit_cnt_q + LOG2N'(1);
        end
        wr_bank_d     = wr_bank_q ^ last_beat;
        rd_bank_d     = rd_bank_q ^ frame_release;
        frame_count_d = frame_count_q + FCNT_W'(last_beat);

`ifdef LLR_FRAME_LOADER_ERASURE_EN
        rd_visible = bank_data[rd_bank_q] & ~bank_mask[rd_bank_q];
`else
        rd_visible = bank_data[rd_bank_q];
`endif
        frame_data = frame_valid ? rd_visible : '0;

        // Decode rd_addr explicitly so indices N..2**LOG2N-1 read as a miss.
        rd_hit = 1'b0;
        rd_bit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rd_addr == LOG2N'(i)) begin
`ifdef LLR_FRAME_LOADER_ERASURE_EN
                rd_hit = !bank_mask[rd_bank_q][i];
`else
                rd_hit = 1'b1;
`endif
                rd_bit = rd_visible[i];
            end
        end
        // Uses rd_bank_q, i.e. the bank before any same-cycle release.
        llr_out_d = (frame_valid && rd_hit)
                  ? llr_from_bit(rd_bit, bank_mag[rd_bank_q])
                  : LLR_ZERO;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            bit_cnt_q     <= '0;
            frame_count_q <= '0;
            llr_out_q     <= LLR_ZERO;
        end else begin
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_count_q <= frame_count_d;
            llr_out_q     <= llr_out_d;
        end
    end

    assign llr_out     = llr_out_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_llr_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_llr_frame_loader
// Directed bench for llr_frame_loader. Inputs change and outputs are sampled
// 1 ns after each rising edge. Define LLR_FRAME_LOADER_ERASURE_EN to also
// exercise the erasure mask.
// ---------------------------------------------------------------------------
module tb_llr_frame_loader;

    logic        clk;
    logic        rst;
    logic [14:0] llr_mag;
    logic        din;
    logic        din_valid;
    logic        din_ready;
`ifdef LLR_FRAME_LOADER_ERASURE_EN
    logic        din_erase;
`endif
    logic        frame_valid;
    logic [11:0] frame_data;
    logic        frame_done;
    logic [3:0]  rd_addr;
    logic [15:0] llr_out;
    logic [15:0] frame_count;

    int vectors     = 0;
    int miscompares = 0;

    llr_frame_loader dut (
        .clk         (clk),
        .rst         (rst),
        .llr_mag     (llr_mag),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
`ifdef LLR_FRAME_LOADER_ERASURE_EN
        .din_erase   (din_erase),
`endif
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_done  (frame_done),
        .rd_addr     (rd_addr),
        .llr_out     (llr_out),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed bits lo..hi of a frame pattern (bit i is the i-th serial bit).
    task automatic feed(input logic [11:0] bits, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            din       = bits[i];
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
    endtask

`ifdef LLR_FRAME_LOADER_ERASURE_EN
    task automatic feed_erase(input logic [11:0] bits, input int erase_idx);
        for (int i = 0; i < 12; i++) begin
            din       = bits[i];
            din_erase = (i == erase_idx);
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        din_erase = 1'b0;
    endtask
`endif

    task automatic pulse_done();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    task automatic read_llr(input string tag, input logic [3:0] addr, input logic [15:0] exp);
        rd_addr = addr;
        step();
        check(tag, llr_out, exp);
    endtask

    initial begin
        rst        = 1'b0;
        llr_mag    = 15'h0100;
        din        = 1'b0;
        din_valid  = 1'b0;
        frame_done = 1'b0;
        rd_addr    = 4'd0;
`ifdef LLR_FRAME_LOADER_ERASURE_EN
        din_erase  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_din_ready",   16'(din_ready),   16'h1);
        check("rst_frame_valid", 16'(frame_valid), 16'h0);
        check("rst_frame_data",  16'(frame_data),  16'h0);
        check("rst_llr_out",     llr_out,          16'h0);
        check("rst_frame_count", frame_count,      16'h0);
        rst = 1'b1;
        step();

        // Frame A = 0x955 into bank 0, magnitude 0x0100
        feed(12'h955, 0, 10);
        check("a_valid_before_last", 16'(frame_valid), 16'h0);
        feed(12'h955, 11, 11);
        check("a_frame_valid", 16'(frame_valid), 16'h1);
        check("a_frame_data",  16'(frame_data),  16'h955);
        check("a_frame_count", frame_count,      16'h1);
        check("a_din_ready",   16'(din_ready),   16'h1);
        read_llr("a_llr0", 4'd0, 16'hFF00);
        read_llr("a_llr1", 4'd1, 16'h0100);

        // Frame B = 0x3A6 into bank 1, magnitude changes mid-frame to 0x0280
        feed(12'h3A6, 0, 5);
        llr_mag = 15'h0280;
        feed(12'h3A6, 6, 11);
        check("b_din_ready_low", 16'(din_ready),   16'h0);
        check("b_frame_count",   frame_count,      16'h2);
        check("b_rd_still_a",    16'(frame_data),  16'h955);

        // Both banks full: offered bit of frame C must stay unaccepted
        din       = 1'b1;
        din_valid = 1'b1;
        repeat (3) step();
        check("stall_din_ready", 16'(din_ready), 16'h0);
        check("stall_count",     frame_count,    16'h2);
        read_llr("a_llr2_keep_mag", 4'd2, 16'hFF00);
        read_llr("a_llr1_keep_mag", 4'd1, 16'h0100);

        // Release bank 0 while din is still offered
        pulse_done();
        din_valid = 1'b0;
        check("rel_din_ready",   16'(din_ready),   16'h1);
        check("rel_frame_valid", 16'(frame_valid), 16'h1);
        check("rel_frame_data",  16'(frame_data),  16'h3A6);
        check("rel_count",       frame_count,      16'h2);
        read_llr("b_llr0", 4'd0, 16'h0280);
        read_llr("b_llr1", 4'd1, 16'hFD80);

        // Frame C = 0xC3F into bank 0; any stray accepted bit would shift it
        feed(12'hC3F, 0, 11);
        check("c_count",     frame_count,    16'h3);
        check("c_din_ready", 16'(din_ready), 16'h0);
        check("c_rd_still_b", 16'(frame_data), 16'h3A6);
        pulse_done();
        check("c_frame_data", 16'(frame_data), 16'hC3F);

        // Frame D = 0x5A3: last bit into bank 1 in the same cycle bank 0 is released
        feed(12'h5A3, 0, 10);
        din        = 1'b0;          // bit 11 of 0x5A3
        din_valid  = 1'b1;
        frame_done = 1'b1;
        step();
        din_valid  = 1'b0;
        frame_done = 1'b0;
        check("sim_frame_valid", 16'(frame_valid), 16'h1);
        check("sim_frame_data",  16'(frame_data),  16'h5A3);
        check("sim_count",       frame_count,      16'h4);
        check("sim_din_ready",   16'(din_ready),   16'h1);
        read_llr("d_llr0", 4'd0, 16'hFD80);

        // Release D: no frame valid, then a release that must be ignored
        pulse_done();
        check("empty_frame_valid", 16'(frame_valid), 16'h0);
        check("empty_frame_data",  16'(frame_data),  16'h0);
        pulse_done();
        read_llr("empty_llr", 4'd0, 16'h0000);

        // Frame E = 0x0F0 into bank 0; rd_bank must still point at bank 0
        llr_mag = 15'h0100;
        feed(12'h0F0, 0, 11);
        check("e_frame_valid", 16'(frame_valid), 16'h1);
        check("e_frame_data",  16'(frame_data),  16'h0F0);
        check("e_count",       frame_count,      16'h5);
        read_llr("e_llr4",  4'd4,  16'hFF00);
        read_llr("e_llr12", 4'd12, 16'h0000);
        read_llr("e_llr11", 4'd11, 16'h0100);
        read_llr("e_llr15", 4'd15, 16'h0000);
        read_llr("e_llr5",  4'd5,  16'hFF00);

        // Asynchronous reset after 7 bits of frame F
        feed(12'hABC, 0, 6);
        #3;
        rst = 1'b0;
        #1;
        check("arst_din_ready",   16'(din_ready),   16'h1);
        check("arst_frame_valid", 16'(frame_valid), 16'h0);
        check("arst_frame_data",  16'(frame_data),  16'h0);
        check("arst_llr_out",     llr_out,          16'h0);
        check("arst_count",       frame_count,      16'h0);
        step();
        rst = 1'b1;
        step();
        feed(12'h955, 0, 11);
        check("post_frame_valid", 16'(frame_valid), 16'h1);
        check("post_frame_data",  16'(frame_data),  16'h955);
        check("post_count",       frame_count,      16'h1);
        read_llr("post_llr0", 4'd0, 16'hFF00);

`ifdef LLR_FRAME_LOADER_ERASURE_EN
        // Frame 0xFFF with bit 3 erased goes to bank 1
        feed_erase(12'hFFF, 3);
        pulse_done();
        check("era_frame_data", 16'(frame_data), 16'hFF7);
        read_llr("era_llr3", 4'd3, 16'h0000);
        read_llr("era_llr4", 4'd4, 16'hFF00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
